// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control unit: a Moore FSM that sequences one
// instruction through fetch, decode, execute, memory and write-back states,
// driving the datapath strobes and selects for each state.
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   opcode[5:0]    IR[31:26], looked at in DECODE (and MEM_ADDR for LW/SW)
//   zero           ALU zero flag, used for the branch PC enable
//   mem_ready      memory handshake, access completes in any cycle it is 1
//   pc_write .. alu_src_a   single-bit datapath strobes/selects
//   alu_src_b[1:0] 00 reg B, 01 const 4, 10 sext imm, 11 sext imm<<2
//   alu_op[1:0]    00 add, 01 subtract, 10 funct-decoded
//   pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   pc_en          PC load enable = pc_write | (pc_write_cond & zero)
//   illegal_op     one-cycle pulse in DECODE on an unrecognised opcode
//   state[3:0]     current state, for debug
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEM_ADDR = 4'd2;
  localparam logic [3:0] MEM_RD   = 4'd3;
  localparam logic [3:0] MEM_WB   = 4'd4;
  localparam logic [3:0] MEM_WR   = 4'd5;
  localparam logic [3:0] EXEC     = 4'd6;
  localparam logic [3:0] R_WB     = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] JUMP     = 4'd9;
  localparam logic [3:0] ADDI_EX  = 4'd10;
  localparam logic [3:0] ADDI_WB  = 4'd11;

  logic [3:0] state_q;
  logic [3:0] state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_R:         state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default:      state_d = FETCH;
        endcase
      end
      // opcode is still held in the IR here, so it picks load vs store
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      EXEC:     state_d = R_WB;
      R_WB:     state_d = FETCH;
      BRANCH:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      ADDI_EX:  state_d = ADDI_WB;
      ADDI_WB:  state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  // Output decode; everything is forced low while rst_n is low so an access
  // in flight is dropped the moment reset asserts.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR and PC only capture on the cycle the fetch completes
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
          default:                                  illegal_op = 1'b1;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      ADDI_WB: begin
        reg_write = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
    end
  end

  assign pc_en = pc_write | (pc_write_cond & zero);
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM with hand-computed state sequences and output values.
module tb_multicycle_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       pc_en, illegal_op;
  logic [3:0] state;

  int compared;
  int mismatched;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .pc_en(pc_en),
    .illegal_op(illegal_op), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    opcode     = 6'h00;
    zero       = 1'b1;
    mem_ready  = 1'b1;

    // Reset: state FETCH, every output low even with mem_ready=1
    cyc(); cyc();
    check("rst_state", state, 4'd0);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_pc_en", pc_en, 1'b0);
    check("rst_ir_write", ir_write, 1'b0);
    check("rst_alu_src_b", alu_src_b, 2'b00);
    rst_n = 1'b1;
    #1;

    // FETCH wait: hold with mem_read up, no IR/PC capture
    mem_ready = 1'b0;
    #1;
    check("fw_state", state, 4'd0);
    check("fw_mem_read", mem_read, 1'b1);
    check("fw_ir_write", ir_write, 1'b0);
    check("fw_pc_en", pc_en, 1'b0);
    cyc();
    check("fw_state_hold", state, 4'd0);
    mem_ready = 1'b1;
    #1;

    // R-type: 0,1,6,7,0
    opcode = 6'h00;
    check("r_f_ir_write", ir_write, 1'b1);
    check("r_f_pc_en", pc_en, 1'b1);
    check("r_f_alu_src_b", alu_src_b, 2'b01);
    begin
      logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
      for (int i = 0; i < 5; i++) begin
        check($sformatf("r_seq%0d", i), state, seq[i]);
        check($sformatf("r_regwr%0d", i), reg_write, (i == 3));
        check($sformatf("r_regdst%0d", i), reg_dst, (i == 3));
        if (i == 1) check("r_dec_alu_src_b", alu_src_b, 2'b11);
        if (i == 2) check("r_exec_alu_op", alu_op, 2'b10);
        if (i < 4) cyc();
      end
    end

    // LW with two wait cycles in MEM_RD: 0,1,2,3,3,3,4,0
    opcode = 6'h23;
    begin
      logic [3:0] seq [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
      for (int i = 0; i < 8; i++) begin
        mem_ready = !(i == 3 || i == 4);
        #1;
        check($sformatf("lw_seq%0d", i), state, seq[i]);
        if (i >= 3 && i <= 5) begin
          check($sformatf("lw_mem_read%0d", i), mem_read, 1'b1);
          check($sformatf("lw_i_or_d%0d", i), i_or_d, 1'b1);
        end
        if (i == 2) check("lw_addr_alu_src_b", alu_src_b, 2'b10);
        if (i == 6) begin
          check("lw_wb_reg_write", reg_write, 1'b1);
          check("lw_wb_mem_to_reg", mem_to_reg, 1'b1);
          check("lw_wb_reg_dst", reg_dst, 1'b0);
        end
        if (i < 7) cyc();
      end
    end
    mem_ready = 1'b1;

    // BEQ taken then not taken
    for (int k = 0; k < 2; k++) begin
      opcode = 6'h04;
      zero   = (k == 0);
      #1;
      check($sformatf("beq%0d_f", k), state, 4'd0);
      cyc();
      check($sformatf("beq%0d_dec", k), state, 4'd1);
      check($sformatf("beq%0d_dec_pc_en", k), pc_en, 1'b0);
      cyc();
      check($sformatf("beq%0d_br", k), state, 4'd8);
      check($sformatf("beq%0d_pc_en", k), pc_en, (k == 0));
      check($sformatf("beq%0d_pc_source", k), pc_source, 2'b01);
      check($sformatf("beq%0d_alu_op", k), alu_op, 2'b01);
      cyc();
      check($sformatf("beq%0d_back", k), state, 4'd0);
    end

    // Illegal opcode: single-cycle pulse in DECODE, back to FETCH
    opcode = 6'h3F;
    cyc();
    check("ill_dec", state, 4'd1);
    check("ill_pulse", illegal_op, 1'b1);
    check("ill_reg_write", reg_write, 1'b0);
    check("ill_mem_write", mem_write, 1'b0);
    check("ill_pc_en", pc_en, 1'b0);
    cyc();
    check("ill_back", state, 4'd0);
    check("ill_pulse_end", illegal_op, 1'b0);

    // Jump: 0,1,9,0
    opcode = 6'h02;
    cyc();
    check("j_dec", state, 4'd1);
    cyc();
    check("j_state", state, 4'd9);
    check("j_pc_write", pc_write, 1'b1);
    check("j_pc_source", pc_source, 2'b10);
    check("j_pc_en", pc_en, 1'b1);
    cyc();
    check("j_back", state, 4'd0);

    // ADDI: 0,1,10,11,0
    opcode = 6'h08;
    cyc(); cyc();
    check("addi_ex", state, 4'd10);
    check("addi_ex_alu_src_b", alu_src_b, 2'b10);
    check("addi_ex_alu_src_a", alu_src_a, 1'b1);
    cyc();
    check("addi_wb", state, 4'd11);
    check("addi_wb_reg_write", reg_write, 1'b1);
    check("addi_wb_reg_dst", reg_dst, 1'b0);
    check("addi_wb_mem_to_reg", mem_to_reg, 1'b0);
    cyc();
    check("addi_back", state, 4'd0);

    // SW stalled in MEM_WR, then reset mid-access
    opcode = 6'h2B;
    cyc(); cyc();
    check("sw_addr", state, 4'd2);
    mem_ready = 1'b0;
    cyc();
    check("sw_wr", state, 4'd5);
    check("sw_mem_write", mem_write, 1'b1);
    check("sw_i_or_d", i_or_d, 1'b1);
    cyc();
    check("sw_wr_hold", state, 4'd5);
    check("sw_mem_write_hold", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    check("sw_rst_mem_write", mem_write, 1'b0);
    check("sw_rst_state", state, 4'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    check("post_rst_state", state, 4'd0);
    check("post_rst_pc_en_wait", pc_en, 1'b0);
    check("post_rst_mem_read", mem_read, 1'b1);
    cyc();
    check("post_rst_hold", state, 4'd0);
    mem_ready = 1'b1;
    #1;
    check("post_rst_pc_en", pc_en, 1'b1);
    cyc();
    check("post_rst_dec", state, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
